// File: rtl/pipeline_pkg.sv
// Shared pipeline-control types: FSM state encoding and memory-wait timeout default.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_BR_FLUSH   = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_t;

  localparam int WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds either source of the instruction in ID.
module hazard_detect (
  input  logic       i_id_ex_memread,
  input  logic [4:0] i_id_ex_rt,
  input  logic [4:0] i_if_id_rs,
  input  logic [4:0] i_if_id_rt,
  output logic       o_load_use
);

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign o_load_use = i_id_ex_memread && (i_id_ex_rt != 5'd0) &&
                      ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, taken-branch flush, one-bubble load-use stall.
// Enables/flushes are a combinational decode of state and inputs; stall counter and timeout flag are registered.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        EX_MEM_Branch,
  input  logic        EX_MEM_Zero,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        Mem_Ready,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        ID_EX_En,
  output logic        EX_MEM_En,
  output logic        MEM_WB_En,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        PCSrc,
  output logic [15:0] Stall_Count,
  output logic        Timeout_Err
);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_timeout;

  logic        w_load_use;
  logic        w_mem_pend;
  logic        w_taken;
  logic        w_wait_max;
  logic [4:0]  w_en;
  logic [2:0]  w_flush;
  logic        w_pcsrc;
  state_t      w_nxt_state;

  hazard_detect u_hazard_detect (
    .i_id_ex_memread (ID_EX_MemRead),
    .i_id_ex_rt      (ID_EX_Rt),
    .i_if_id_rs      (IF_ID_Rs),
    .i_if_id_rt      (IF_ID_Rt),
    .o_load_use      (w_load_use)
  );

  assign w_mem_pend = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~Mem_Ready;
  assign w_taken    = EX_MEM_Branch & EX_MEM_Zero & ~w_mem_pend;
  assign w_wait_max = (r_wait_cnt == 8'(WAIT_MAX));

  // w_en is {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}; w_flush is {IF_ID, ID_EX, EX_MEM}.
  always_comb begin
    w_en        = 5'b11111;
    w_flush     = 3'b000;
    w_pcsrc     = 1'b0;
    w_nxt_state = ST_RUN;
    case (r_state)
      ST_RUN, ST_LOAD_STALL: begin
        if (w_mem_pend) begin
          w_en        = 5'b00000;
          w_nxt_state = ST_MEM_WAIT;
        end else if (w_taken) begin
          w_flush     = 3'b111;
          w_pcsrc     = 1'b1;
          w_nxt_state = ST_BR_FLUSH;
        end else if (w_load_use && (r_state == ST_RUN)) begin
          w_en        = 5'b00111;
          w_flush     = 3'b010;
          w_nxt_state = ST_LOAD_STALL;
        end
      end
      ST_MEM_WAIT: begin
        if (w_mem_pend) begin
          w_en        = 5'b00000;
          w_nxt_state = w_wait_max ? ST_RUN : ST_MEM_WAIT;
        end
      end
      default: ;
    endcase
    if (!reset) begin
      w_en    = 5'b00000;
      w_flush = 3'b000;
      w_pcsrc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (w_nxt_state == ST_MEM_WAIT)
        r_wait_cnt <= (r_state == ST_MEM_WAIT) ? r_wait_cnt + 8'd1 : 8'd1;
      else
        r_wait_cnt <= 8'd0;
      if ((r_state == ST_MEM_WAIT) && w_mem_pend && w_wait_max)
        r_timeout <= 1'b1;
      if (!w_en[4] && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign PC_En        = w_en[4];
  assign IF_ID_En     = w_en[3];
  assign ID_EX_En     = w_en[2];
  assign EX_MEM_En    = w_en[1];
  assign MEM_WB_En    = w_en[0];
  assign IF_ID_Flush  = w_flush[2];
  assign ID_EX_Flush  = w_flush[1];
  assign EX_MEM_Flush = w_flush[0];
  assign PCSrc        = w_pcsrc;
  assign Stall_Count  = r_stall_cnt;
  assign Timeout_Err  = r_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, timeout/reset/saturation sequences, random run vs a flag-based model.
module tb_pipeline_ctrl;

  localparam int WM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs = '0, rt = '0, idex_rt = '0;
  logic        idex_mr = 1'b0, br = 1'b0, zero = 1'b0, mr = 1'b0, mw = 1'b0, rdy = 1'b1;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_fl, idex_fl, exmem_fl, pcsrc, tmo_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt),
    .ID_EX_MemRead(idex_mr), .ID_EX_Rt(idex_rt),
    .EX_MEM_Branch(br), .EX_MEM_Zero(zero),
    .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw),
    .Mem_Ready(rdy),
    .PC_En(pc_en), .IF_ID_En(ifid_en), .ID_EX_En(idex_en),
    .EX_MEM_En(exmem_en), .MEM_WB_En(memwb_en),
    .IF_ID_Flush(ifid_fl), .ID_EX_Flush(idex_fl), .EX_MEM_Flush(exmem_fl),
    .PCSrc(pcsrc), .Stall_Count(stall_cnt), .Timeout_Err(tmo_err)
  );

  wire [4:0] act_en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  wire [2:0] act_fl = {ifid_fl, idex_fl, exmem_fl};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: how many wait cycles are outstanding, whether the last cycle was a
  // taken branch or a load-use bubble, plus the two registered observables.
  int       m_wait;
  bit       m_after_br, m_after_ld, m_tmo;
  int       m_sc;
  logic [4:0] e_en;
  logic [2:0] e_fl;
  logic       e_pc;
  int       n_wait;
  bit       n_ab, n_al, n_tmo;

  task automatic model_reset();
    m_wait = 0; m_after_br = 0; m_after_ld = 0; m_tmo = 0; m_sc = 0;
  endtask

  task automatic model_eval();
    bit pend, taken, lu;
    pend  = (mr | mw) & !rdy;
    taken = br & zero & !pend;
    lu    = idex_mr && (idex_rt != 0) && (idex_rt == rs || idex_rt == rt);
    e_en = 5'b11111; e_fl = 3'b000; e_pc = 1'b0;
    n_wait = 0; n_ab = 0; n_al = 0; n_tmo = m_tmo;
    if (m_wait > 0) begin
      if (pend) begin
        e_en = 5'b00000;
        if (m_wait == WM) n_tmo = 1;
        else n_wait = m_wait + 1;
      end
    end else if (m_after_br) begin
      e_en = 5'b11111;
    end else if (pend) begin
      e_en = 5'b00000; n_wait = 1;
    end else if (taken) begin
      e_fl = 3'b111; e_pc = 1'b1; n_ab = 1;
    end else if (lu && !m_after_ld) begin
      e_en = 5'b00111; e_fl = 3'b010; n_al = 1;
    end
  endtask

  task automatic model_commit();
    if (!e_en[4] && m_sc < 65535) m_sc++;
    m_wait = n_wait; m_after_br = n_ab; m_after_ld = n_al; m_tmo = n_tmo;
  endtask

  // One model-checked cycle: inputs already driven; sample at negedge.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, "_ctl"}, {23'd0, act_en, act_fl, pcsrc}, {23'd0, e_en, e_fl, e_pc});
    chk({tag, "_stall_count"}, {16'd0, stall_cnt}, m_sc);
    chk({tag, "_timeout"}, {31'd0, tmo_err}, {31'd0, m_tmo});
    model_commit();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic a_idex_mr, input logic [4:0] a_idex_rt, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic a_br, input logic a_zero,
                        input logic a_mr, input logic a_mw, input logic a_rdy);
    idex_mr = a_idex_mr; idex_rt = a_idex_rt; rs = a_rs; rt = a_rt;
    br = a_br; zero = a_zero; mr = a_mr; mw = a_mw; rdy = a_rdy;
  endtask

  typedef struct {
    logic       idex_mr;
    logic [4:0] idex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br, zero, mr, mw, rdy;
    logic [4:0] en;
    logic [2:0] fl;
    logic       pc;
    logic [15:0] sc;
  } vec_t;

  function automatic vec_t v(input logic a_mr_id, input logic [4:0] a_idrt, input logic [4:0] a_rs,
                             input logic [4:0] a_rt, input logic a_br, input logic a_z,
                             input logic a_mr, input logic a_mw, input logic a_rdy,
                             input logic [4:0] a_en, input logic [2:0] a_fl, input logic a_pc,
                             input logic [15:0] a_sc);
    vec_t r;
    r.idex_mr = a_mr_id; r.idex_rt = a_idrt; r.rs = a_rs; r.rt = a_rt;
    r.br = a_br; r.zero = a_z; r.mr = a_mr; r.mw = a_mw; r.rdy = a_rdy;
    r.en = a_en; r.fl = a_fl; r.pc = a_pc; r.sc = a_sc;
    return r;
  endfunction

  vec_t tbl[18];

  initial begin
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 0);  // idle
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 0);  // load waits on memory
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 1);
    tbl[3]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 3'b000, 0, 2);
    tbl[4]  = v(0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b11111, 3'b000, 0, 3);  // memory ready
    tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 3);
    tbl[6]  = v(1, 8, 8, 0, 0, 0, 0, 0, 1, 5'b00111, 3'b010, 0, 3);  // load-use on Rs
    tbl[7]  = v(1, 8, 8, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 4);  // not re-detected
    tbl[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 4);
    tbl[9]  = v(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 4);  // $zero destination
    tbl[10] = v(1, 8, 8, 0, 1, 1, 0, 0, 1, 5'b11111, 3'b111, 1, 4);  // taken branch beats load-use
    tbl[11] = v(1, 8, 8, 0, 1, 1, 0, 0, 1, 5'b11111, 3'b000, 0, 4);  // flush cycle ignores both
    tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 4);
    tbl[13] = v(0, 0, 0, 0, 1, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 4);  // branch not taken
    tbl[14] = v(0, 0, 0, 0, 1, 1, 0, 1, 0, 5'b00000, 3'b000, 0, 4);  // store pending beats branch
    tbl[15] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 3'b000, 0, 5);
    tbl[16] = v(1, 5, 3, 5, 0, 0, 0, 0, 1, 5'b00111, 3'b010, 0, 5);  // load-use on Rt
    tbl[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 3'b000, 0, 6);

    // Reset state
    #3;
    chk("reset_ctl", {23'd0, act_en, act_fl, pcsrc}, 32'd0);
    chk("reset_stall_count", {16'd0, stall_cnt}, 32'd0);
    chk("reset_timeout", {31'd0, tmo_err}, 32'd0);
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].idex_mr, tbl[i].idex_rt, tbl[i].rs, tbl[i].rt, tbl[i].br, tbl[i].zero,
             tbl[i].mr, tbl[i].mw, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), {27'd0, act_en}, {27'd0, tbl[i].en});
      chk($sformatf("vec%0d_flush", i), {29'd0, act_fl}, {29'd0, tbl[i].fl});
      chk($sformatf("vec%0d_pcsrc", i), {31'd0, pcsrc}, {31'd0, tbl[i].pc});
      chk($sformatf("vec%0d_stall_count", i), {16'd0, stall_cnt}, {16'd0, tbl[i].sc});
      chk($sformatf("vec%0d_timeout", i), {31'd0, tmo_err}, 32'd0);
      model_eval();
      model_commit();
      @(posedge clk); #1;
    end

    // Timeout: memory never ready, WM wait cycles in MEM_WAIT after the entry cycle
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i <= WM; i++) step("timeout_wait");
    chk("timeout_set", {31'd0, tmo_err}, 32'd1);
    step("timeout_reenter");
    rdy = 1'b1;
    step("timeout_release");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("timeout_idle");
    chk("timeout_sticky", {31'd0, tmo_err}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 6));
      step("rand");
    end

    // Reset asserted in the middle of a memory wait
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("rstwait_a");
    step("rstwait_b");
    #2 reset = 1'b0;
    #1;
    chk("rstwait_ctl", {23'd0, act_en, act_fl, pcsrc}, 32'd0);
    chk("rstwait_stall_count", {16'd0, stall_cnt}, 32'd0);
    chk("rstwait_timeout", {31'd0, tmo_err}, 32'd0);
    @(posedge clk); #1;
    chk("rstwait_held_ctl", {23'd0, act_en, act_fl, pcsrc}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    step("rstwait_release");
    chk("rstwait_run_en", {27'd0, act_en}, 32'h1F);

    // Saturation: hold a memory stall long enough to pin the counter
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_near_max", {16'd0, stall_cnt}, 32'h0000FFFE);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_max", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_pc_en_low", {31'd0, pc_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
